// File: rtl/qsys_pio_irq_n.sv
// Parallel input port with edge capture and a level interrupt.
// Inputs are synchronized, optionally debounced, and edge-detected. Enabled
// rising/falling edges latch into edge_capture. Software clears those bits by
// writing 1 to them.
module qsys_pio_irq_n #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_RISE = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_FALL = 3'd4;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] deb_prev_q;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rise, fall, clr;

    // Only the low WIDTH bits of writedata carry register content.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // Two-flop synchronizer, then a pipeline stage holding the previous debounced value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            // Without debounce the debounced value just follows the synchronizer.
            always_comb begin
                deb_d = sync2_q;
            end
        end else begin : g_deb
            localparam int unsigned    CNT_W    = 16;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

            // Per-channel stability counter; deb flips once the change has persisted long enough.
            always_comb begin
                deb_d = deb_q;
                cnt_d = '0;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if (sync2_q[i] != deb_q[i]) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            deb_d[i] = sync2_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end

            // Counter state; reset abandons any count in progress.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Register writes, edge capture with set-priority over clear, and the read mux.
    always_comb begin
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_mask_d = irq_mask_q;
        readdata_d = '0;

        wr_en = chipselect & ~write_n;
        wdata = writedata[WIDTH-1:0];
        rise  = deb_q & ~deb_prev_q;
        fall  = ~deb_q & deb_prev_q;
        clr   = (wr_en && address == ADDR_EDGE) ? wdata : '0;

        if (wr_en) begin
            case (address)
                ADDR_RISE: rise_en_d  = wdata;
                ADDR_MASK: irq_mask_d = wdata;
                ADDR_FALL: fall_en_d  = wdata;
                default:   ;
            endcase
        end

        edge_cap_d = (edge_cap_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);

        case (address)
            ADDR_DATA: readdata_d = 32'(deb_q);
            ADDR_RISE: readdata_d = 32'(rise_en_q);
            ADDR_MASK: readdata_d = 32'(irq_mask_q);
            ADDR_EDGE: readdata_d = 32'(edge_cap_q);
            ADDR_FALL: readdata_d = 32'(fall_en_q);
            default:   readdata_d = '0;
        endcase
    end

    // Control/status registers and the registered read port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
        end else begin
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_qsys_pio_irq_n.sv
// Bench for qsys_pio_irq_n: scoreboarded directed and random traffic on an
// undebounced instance, plus directed glitch/level checks on a debounced one.
module tb_qsys_pio_irq_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Undebounced instance.
    logic        reset_n, chipselect, write_n, irq;
    logic [2:0]  address;
    logic [31:0] writedata, readdata;
    logic [7:0]  in_port;

    // Debounced instance (16 cycles).
    logic        d_reset_n, d_chipselect, d_write_n, d_irq;
    logic [2:0]  d_address;
    logic [31:0] d_writedata, d_readdata;
    logic [7:0]  d_in_port;

    int checks = 0;
    int errors = 0;

    qsys_pio_irq_n #(.WIDTH(8), .DEBOUNCE_CYCLES(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    qsys_pio_irq_n #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) u_deb (
        .clk(clk), .reset_n(d_reset_n), .address(d_address), .chipselect(d_chipselect),
        .write_n(d_write_n), .writedata(d_writedata), .in_port(d_in_port),
        .readdata(d_readdata), .irq(d_irq)
    );

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] hist [0:3];   // hist[j] = in_port sampled j+1 edges ago (zeroed by reset)
    logic [7:0] m_ren = '0, m_fen = '0, m_msk = '0, m_ec = '0;

    initial for (int j = 0; j < 4; j++) hist[j] = '0;

    // At each edge: the visible pin value lags in_port by 3 edges, edges are
    // seen one edge later, and readdata shows the register state before the edge.
    always @(posedge clk) begin : model
        logic [7:0]  rise, fall, det, clr, wd, deb;
        logic [31:0] rd;
        logic        wr;
        deb  = hist[2];
        rise = hist[2] & ~hist[3];
        fall = ~hist[2] & hist[3];
        wr   = chipselect && !write_n;
        wd   = writedata[7:0];
        case (address)
            3'd0:    rd = {24'd0, deb};
            3'd1:    rd = {24'd0, m_ren};
            3'd2:    rd = {24'd0, m_msk};
            3'd3:    rd = {24'd0, m_ec};
            3'd4:    rd = {24'd0, m_fen};
            default: rd = 32'd0;
        endcase
        det  = (rise & m_ren) | (fall & m_fen);
        clr  = (wr && address == 3'd3) ? wd : 8'd0;
        m_ec = (m_ec & ~clr) | det;
        if (wr && address == 3'd1) m_ren = wd;
        if (wr && address == 3'd2) m_msk = wd;
        if (wr && address == 3'd4) m_fen = wd;
        for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = in_port;
        if (!reset_n) begin
            m_ren = '0; m_fen = '0; m_msk = '0; m_ec = '0; rd = '0;
            for (int j = 0; j < 4; j++) hist[j] = '0;
        end
        expq.push_back('{rd: rd, irq: |(m_ec & m_msk)});
    end

    // Monitor: compare each cycle's registered readdata and irq.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: no expected entry at %0t", $time);
        end else begin
            e = expq.pop_front();
            checks++;
            if (readdata !== e.rd) begin
                errors++;
                $display("FAIL readdata @%0t: got %h expected %h", $time, readdata, e.rd);
            end
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL irq @%0t: got %b expected %b", $time, irq, e.irq);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic rn, input logic cs, input logic [2:0] a, input logic [31:0] wd);
        @(negedge clk);
        reset_n    = rn;
        chipselect = cs;
        write_n    = ~cs;
        address    = a;
        writedata  = wd;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        step(1'b1, 1'b1, a, wd);
    endtask

    task automatic idle(input logic [2:0] a, input int n);
        repeat (n) step(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic d_step(input logic rn, input logic cs, input logic [2:0] a, input logic [31:0] wd);
        @(negedge clk);
        d_reset_n    = rn;
        d_chipselect = cs;
        d_write_n    = ~cs;
        d_address    = a;
        d_writedata  = wd;
    endtask

    task automatic dchk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0; in_port = '0;
        d_reset_n = 1'b0; d_chipselect = 1'b0; d_write_n = 1'b1; d_address = '0; d_writedata = '0; d_in_port = '0;

        repeat (3) step(1'b0, 1'b0, 3'd0, 32'd0);

        // Rising edge on bit 0 with irq enabled, then W1C clear.
        wr(3'd1, 32'h01); wr(3'd2, 32'h01); idle(3'd3, 2);
        in_port[0] = 1'b1;
        idle(3'd3, 6);
        wr(3'd3, 32'h01); idle(3'd3, 3);

        // Fall-only capture on bit 7.
        wr(3'd1, 32'h00); wr(3'd4, 32'h80); wr(3'd2, 32'h00);
        in_port[7] = 1'b1; idle(3'd3, 6);
        in_port[7] = 1'b0; idle(3'd3, 6);

        // Clear of bit 2 collides with a fresh rising edge on bit 2.
        wr(3'd1, 32'h04); wr(3'd4, 32'h00); wr(3'd3, 32'hFF); idle(3'd3, 2);
        in_port[2] = 1'b1;
        idle(3'd3, 2);
        wr(3'd3, 32'h04);
        idle(3'd3, 3);

        // Mask removal drops irq but keeps edge_capture; unmapped address reads 0.
        wr(3'd3, 32'hFF); in_port = 8'h00; wr(3'd1, 32'h03); idle(3'd3, 5);
        in_port[1:0] = 2'b11; idle(3'd3, 6);
        wr(3'd2, 32'h02); idle(3'd3, 2);
        wr(3'd2, 32'h00); idle(3'd3, 2);
        wr(3'd6, 32'hFFFF_FFFF); idle(3'd6, 2);

        // Everything captured and unmasked, then a one-cycle reset.
        in_port = 8'h00; wr(3'd1, 32'hFF); idle(3'd0, 5);
        in_port = 8'hFF; idle(3'd3, 6);
        wr(3'd2, 32'hFF); idle(3'd3, 2);
        step(1'b0, 1'b0, 3'd3, 32'd0);
        idle(3'd3, 2); idle(3'd2, 2); idle(3'd1, 2); idle(3'd0, 6);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset_n    = ($urandom_range(0, 199) != 0);
            chipselect = 1'($urandom);
            write_n    = 1'($urandom);
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) in_port = in_port ^ 8'($urandom);
        end
        idle(3'd0, 2);

        // Debounced instance: 10-cycle glitch is rejected.
        repeat (3) d_step(1'b0, 1'b0, 3'd0, 32'd0);
        d_step(1'b1, 1'b1, 3'd1, 32'h04);
        d_step(1'b1, 1'b1, 3'd2, 32'h04);
        repeat (5) d_step(1'b1, 1'b0, 3'd0, 32'd0);
        d_in_port[2] = 1'b1;
        repeat (10) d_step(1'b1, 1'b0, 3'd0, 32'd0);
        d_in_port[2] = 1'b0;
        repeat (30) d_step(1'b1, 1'b0, 3'd0, 32'd0);
        dchk("deb_glitch_data", d_readdata, 32'h0);
        dchk("deb_glitch_irq", {31'd0, d_irq}, 32'h0);
        repeat (2) d_step(1'b1, 1'b0, 3'd3, 32'd0);
        dchk("deb_glitch_edge", d_readdata, 32'h0);

        // Debounced instance: a sustained level passes after 16 stable cycles.
        d_step(1'b1, 1'b0, 3'd0, 32'd0);
        d_in_port[2] = 1'b1;
        repeat (12) d_step(1'b1, 1'b0, 3'd0, 32'd0);
        dchk("deb_level_early", d_readdata, 32'h0);
        repeat (8) d_step(1'b1, 1'b0, 3'd0, 32'd0);
        d_in_port[2] = 1'b0;
        repeat (10) d_step(1'b1, 1'b0, 3'd0, 32'd0);
        dchk("deb_level_data", d_readdata, 32'h04);
        repeat (2) d_step(1'b1, 1'b0, 3'd3, 32'd0);
        dchk("deb_level_edge", d_readdata, 32'h04);
        dchk("deb_level_irq", {31'd0, d_irq}, 32'h1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
